// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
//   Time-multiplexed driver for an eight-digit, common-anode 7-segment display.
//   A full frame (eight 5-bit character codes, decimal points, digit enables)
//   is loaded through a valid/ready port into a pending buffer. The pending
//   buffer is promoted to the active buffer only at the scan wrap (digit 7 -> 0),
//   so the display never shows a torn frame. Each digit is held for
//   REFRESH_DIV clock cycles.
//
// Ports
//   CLK100MHZ   in   system clock, rising edge
//   CPU_RESETN  in   asynchronous active-low reset
//   disp_data   in   [39:0] character codes, digit i = [5i+4:5i], digit 0 rightmost
//   disp_dp     in   [7:0]  decimal point per digit, 1 = lit
//   disp_en     in   [7:0]  digit enable, 0 = digit dark
//   load_valid  in   frame offered on disp_data/disp_dp/disp_en
//   load_ready  out  pending buffer empty, a load can be accepted
//   AN          out  [7:0] digit anodes, active-low, bit i = digit i
//   SEG         out  [6:0] {CA..CG}, active-low, SEG[6] = CA
//   DP          out  decimal point, active-low
//   frame_tick  out  one-cycle pulse, high while digit 0 first appears on AN

module sevenseg_scan_driver #(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [39:0] disp_data,
  input  logic [7:0]  disp_dp,
  input  logic [7:0]  disp_en,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        frame_tick
);

  localparam int             PW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_TC = PW'(REFRESH_DIV - 1);
  localparam logic [39:0]    BLANK_FRAME = {8{5'h10}};

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic          tc;
  logic          wrap;
  logic          wrap_q;

  logic          full;
  logic [39:0]   pend_data;
  logic [7:0]    pend_dp;
  logic [7:0]    pend_en;
  logic [39:0]   act_data;
  logic [7:0]    act_dp;
  logic [7:0]    act_en;
  logic          accept;

  logic [4:0]    code_cur;
  logic          en_cur;
  logic          dp_cur;

  function automatic logic [6:0] font(input logic [4:0] code);
    logic [6:0] seg;
    case (code)
      5'h00: seg = 7'h01;
      5'h01: seg = 7'h4F;
      5'h02: seg = 7'h12;
      5'h03: seg = 7'h06;
      5'h04: seg = 7'h4C;
      5'h05: seg = 7'h24;
      5'h06: seg = 7'h20;
      5'h07: seg = 7'h0F;
      5'h08: seg = 7'h00;
      5'h09: seg = 7'h04;
      5'h0A: seg = 7'h08;
      5'h0B: seg = 7'h60;
      5'h0C: seg = 7'h31;
      5'h0D: seg = 7'h42;
      5'h0E: seg = 7'h30;
      5'h0F: seg = 7'h38;
      5'h11: seg = 7'h7E;
      5'h12: seg = 7'h71;
      5'h13: seg = 7'h48;
      5'h14: seg = 7'h18;
      5'h15: seg = 7'h7A;
      5'h16: seg = 7'h6A;
      5'h17: seg = 7'h41;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  assign tc         = (presc == PRESC_TC);
  assign wrap       = tc && (idx == 3'd7);
  assign load_ready = ~full;
  assign accept     = load_valid && !full;

  // Refresh prescaler and digit index
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      presc  <= '0;
      idx    <= 3'd0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap;
      if (tc) begin
        presc <= '0;
        idx   <= idx + 3'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Double buffer. Commit and accept never coincide: accept requires !full,
  // commit requires full.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      full      <= 1'b0;
      pend_data <= BLANK_FRAME;
      pend_dp   <= 8'h00;
      pend_en   <= 8'h00;
      act_data  <= BLANK_FRAME;
      act_dp    <= 8'h00;
      act_en    <= 8'h00;
    end else begin
      if (wrap && full) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
        act_en   <= pend_en;
        full     <= 1'b0;
      end
      if (accept) begin
        pend_data <= disp_data;
        pend_dp   <= disp_dp;
        pend_en   <= disp_en;
        full      <= 1'b1;
      end
    end
  end

  assign code_cur = act_data[5*idx +: 5];
  assign en_cur   = act_en[idx];
  assign dp_cur   = act_dp[idx];

  // Pin registers: AN, SEG and DP all update on the same edge. frame_tick is
  // delayed one extra cycle from the wrap so it lines up with digit 0 on AN.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      AN         <= 8'hFF;
      SEG        <= 7'h7F;
      DP         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      AN         <= en_cur ? ~(8'd1 << idx) : 8'hFF;
      SEG        <= en_cur ? font(code_cur) : 7'h7F;
      DP         <= ~(dp_cur & en_cur);
      frame_tick <= wrap_q;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
module tb_sevenseg_scan_driver;

  logic        CLK100MHZ;
  logic        CPU_RESETN;
  logic [39:0] disp_data;
  logic [7:0]  disp_dp;
  logic [7:0]  disp_en;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;

  logic [6:0] font_exp [32];

  sevenseg_scan_driver #(.REFRESH_DIV(4)) dut (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .disp_data  (disp_data),
    .disp_dp    (disp_dp),
    .disp_en    (disp_en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .AN         (AN),
    .SEG        (SEG),
    .DP         (DP),
    .frame_tick (frame_tick)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  // Advance until frame_tick is seen (at least one cycle); n = cycles advanced.
  task automatic wait_tick(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_tick && n < 200);
    chk(tag, {31'd0, frame_tick}, 32'd1);
  endtask

  task automatic load_frame(input logic [39:0] d, input logic [7:0] dp, input logic [7:0] en);
    int n;
    disp_data  = d;
    disp_dp    = dp;
    disp_en    = en;
    load_valid = 1'b1;
    n = 0;
    while (!load_ready && n < 400) begin
      step();
      n++;
    end
    step();
    load_valid = 1'b0;
    chk("ready_fall", {31'd0, load_ready}, 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] an_e;
    logic [6:0] seg_e;
    logic [6:0] aloha_seg [5];

    font_exp = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38,
                 7'h7F, 7'h7E, 7'h71, 7'h48, 7'h18, 7'h7A, 7'h6A, 7'h41,
                 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    aloha_seg = '{7'h08, 7'h48, 7'h01, 7'h71, 7'h08};

    CPU_RESETN = 1'b0;
    disp_data  = '0;
    disp_dp    = '0;
    disp_en    = '0;
    load_valid = 1'b0;

    // Reset values
    #22;
    chk("rst_an", {24'd0, AN}, 32'hFF);
    chk("rst_seg", {25'd0, SEG}, 32'h7F);
    chk("rst_dp", {31'd0, DP}, 32'd1);
    chk("rst_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_tick", {31'd0, frame_tick}, 32'd0);
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;

    // No load: display stays dark
    for (int c = 0; c < 40; c++) begin
      step();
      chk("idle_an", {24'd0, AN}, 32'hFF);
    end
    chk("idle_ready", {31'd0, load_ready}, 32'd1);

    // ALOHA
    load_frame({5'h10, 5'h10, 5'h10, 5'h0A, 5'h12, 5'h00, 5'h13, 5'h0A}, 8'h00, 8'h1F);
    wait_tick("aloha_tick", n);
    chk("aloha_ready_rise", {31'd0, load_ready}, 32'd1);
    for (int c = 0; c < 32; c++) begin
      if (c / 4 < 5) begin
        an_e  = ~(8'd1 << (c / 4));
        seg_e = aloha_seg[c / 4];
      end else begin
        an_e  = 8'hFF;
        seg_e = 7'h7F;
      end
      chk("aloha_an", {24'd0, AN}, {24'd0, an_e});
      chk("aloha_seg", {25'd0, SEG}, {25'd0, seg_e});
      chk("aloha_dp", {31'd0, DP}, 32'd1);
      chk("aloha_tick", {31'd0, frame_tick}, (c == 0) ? 32'd1 : 32'd0);
      step();
    end
    chk("aloha_repeat_an", {24'd0, AN}, 32'hFE);
    chk("aloha_repeat_tick", {31'd0, frame_tick}, 32'd1);

    // Back-to-back: "9999" then "0000" with load_valid held
    load_frame({5'h10, 5'h10, 5'h10, 5'h10, 5'h09, 5'h09, 5'h09, 5'h09}, 8'h00, 8'h0F);
    disp_data  = {5'h10, 5'h10, 5'h10, 5'h10, 5'h00, 5'h00, 5'h00, 5'h00};
    disp_en    = 8'h0F;
    load_valid = 1'b1;
    step();
    chk("b2b_stall", {31'd0, load_ready}, 32'd0);
    wait_tick("b2b_tick1", n);
    chk("b2b_second_accepted", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      chk("b2b_9_an", {24'd0, AN}, {24'd0, ~(8'd1 << (c / 4))});
      chk("b2b_9_seg", {25'd0, SEG}, 32'h04);
      step();
    end
    wait_tick("b2b_tick2", n);
    chk("b2b_frame_len", n + 16, 32);
    chk("b2b_0_an", {24'd0, AN}, 32'hFE);
    chk("b2b_0_seg", {25'd0, SEG}, 32'h01);
    chk("b2b_ready", {31'd0, load_ready}, 32'd1);

    // Decimal point and enable masking
    load_frame({8{5'h08}}, 8'h03, 8'h01);
    wait_tick("dp_tick", n);
    for (int c = 0; c < 32; c++) begin
      if (c < 4) begin
        chk("dp_an0", {24'd0, AN}, 32'hFE);
        chk("dp_seg0", {25'd0, SEG}, 32'h00);
        chk("dp_dp0", {31'd0, DP}, 32'd0);
      end else begin
        chk("dp_an_off", {24'd0, AN}, 32'hFF);
        chk("dp_seg_off", {25'd0, SEG}, 32'h7F);
        chk("dp_dp_off", {31'd0, DP}, 32'd1);
      end
      step();
    end

    // Font sweep on digit 0
    for (int code = 0; code < 32; code++) begin
      load_frame({{7{5'h10}}, 5'(code)}, 8'h00, 8'h01);
      wait_tick("font_tick", n);
      chk($sformatf("font_%0h", code), {25'd0, SEG}, {25'd0, font_exp[code]});
      chk("font_an", {24'd0, AN}, 32'hFE);
    end

    // Mid-frame reset with a pending load
    load_frame({8{5'h03}}, 8'h00, 8'hFF);
    wait_tick("mid_tick", n);
    chk("mid_shown", {25'd0, SEG}, 32'h06);
    load_frame({8{5'h08}}, 8'hFF, 8'hFF);
    n = 0;
    while (AN !== 8'hF7 && n < 64) begin
      step();
      n++;
    end
    chk("mid_an_f7", {24'd0, AN}, 32'hF7);
    chk("mid_pending", {31'd0, load_ready}, 32'd0);
    CPU_RESETN = 1'b0;
    #1;
    chk("mid_rst_an", {24'd0, AN}, 32'hFF);
    chk("mid_rst_seg", {25'd0, SEG}, 32'h7F);
    chk("mid_rst_dp", {31'd0, DP}, 32'd1);
    chk("mid_rst_ready", {31'd0, load_ready}, 32'd1);
    chk("mid_rst_tick", {31'd0, frame_tick}, 32'd0);
    step();
    step();
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    for (int c = 0; c < 80; c++) begin
      step();
      if (c % 8 == 0) begin
        chk("post_rst_an", {24'd0, AN}, 32'hFF);
        chk("post_rst_seg", {25'd0, SEG}, 32'h7F);
      end
    end
    chk("post_rst_ready", {31'd0, load_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
# sevenseg_scan_driver

Time-multiplexed driver for the board's eight-digit, common-anode 7-segment display. It accepts a full eight-character frame through a valid/ready load port and double-buffers it so that updates take effect only at frame boundaries. It scans the digits with a programmable refresh prescaler and drives the active-low AN, CA–CG and DP pins. It sits between the reaction-timer FSM (score, "9999", "ALOHA" messages) and the display pins, and generates exactly the pin patterns the top-level bench checks.

## Interface
- REFRESH_DIV, 100_000, clock cycles each digit is held (1 kHz per digit at 100 MHz); legal range ≥ 2
- CLK100MHZ  in  1  system clock, all logic on rising edge
- CPU_RESETN  in  1  asynchronous, active-low reset
- disp_data  in  40  eight 5-bit character codes; digit i = [5i+4:5i]; digit 0 is rightmost
- disp_dp  in  8  decimal point per digit, 1 = lit
- disp_en  in  8  digit enable, 0 = digit dark (AN bit held high)
- load_valid  in  1  frame offered on disp_data/disp_dp/disp_en
- load_ready  out  1  pending buffer empty, load can be accepted
- AN  out  8  digit anodes, active-low, bit i = digit i
- SEG  out  7  {CA,CB,CC,CD,CE,CF,CG}, active-low (SEG[6] = CA)
- DP  out  1  decimal point, active-low
- frame_tick  out  1  one-cycle pulse when a new frame starts

## Operation
- Storage: pending buffer (data/dp/en + full flag) and active buffer. The display always shows the active buffer.
- Load: a transfer occurs when load_valid && load_ready at a clock edge. It copies the inputs into pending and sets full. load_ready = !full.
- Commit: at the scan wrap edge (digit 7 → 0), if full, pending is copied to active and full is cleared. A load accepted on the wrap edge itself goes into pending and commits on the next wrap.
- Scan: prescaler counts 0..REFRESH_DIV-1. At terminal count it resets to 0 and the digit index increments mod 8.
- Decode (registered): for current index i:
  - AN = ~(en[i] << i); all ones if en[i] = 0.
  - SEG = font(code[i]) if en[i], else 7F.
  - DP = ~(dp[i] & en[i]).
- Font, SEG hex, active-low:
  - Hex digits: 0:01, 1:4F, 2:12, 3:06, 4:4C, 5:24, 6:20, 7:0F, 8:00, 9:04, A:08, b:60, C:31, d:42, E:30, F:38.
  - Letters and symbols: 0x10 blank:7F, 0x11 '-':7E, 0x12 L:71, 0x13 H:48, 0x14 P:18, 0x15 r:7A, 0x16 n:6A, 0x17 U:41.
  - 0x18–0x1F: blank (7F).
  - 'O' uses code 0x00.
- "ALOHA" = digits 4..0 codes 0A,12,00,13,0A with disp_en = 0x1F.

## Timing
- Reset values:
  - prescaler 0, index 0, full 0.
  - Active buffer: codes 0x10, dp 0, en 0.
  - Outputs: AN = FF, SEG = 7F, DP = 1, load_ready = 1, frame_tick = 0.
- Reset is asynchronous: outputs take reset values immediately, and the pending frame is discarded. Mid-frame reset restarts the scan at digit 0 after release.
- Each digit is shown for exactly REFRESH_DIV cycles; a full frame is 8·REFRESH_DIV cycles.
- Output latency: AN/SEG/DP are registered. They reflect a new index or active buffer one cycle after the edge that changed it. AN and SEG always change on the same edge, so no partial mixes occur.
- Load-to-display latency:
  - Commit happens at the next wrap edge after acceptance; the new frame appears on pins one cycle later.
  - Worst case is 8·REFRESH_DIV + 1 cycles.
- load_ready:
  - Falls the cycle after acceptance.
  - Rises the cycle after the commit edge.
  - A load_valid held while ready = 0 is stalled, not dropped; the source must hold data stable.
- frame_tick is high for exactly the one cycle following each wrap edge, aligned with digit 0 appearing on AN.
- Simultaneous load and commit: with full = 1, ready = 0, so there is no acceptance; the commit empties pending. With full = 0, the new load is accepted and the old active frame stays.
- No combinational path from any input to any output.

## Test plan
- Reset, REFRESH_DIV = 4: hold CPU_RESETN = 0 → AN = FF, SEG = 7F, DP = 1, load_ready = 1, frame_tick = 0. After release, with no load, AN stays FF indefinitely.
- Load ALOHA (en = 1F, dp = 00):
  - Accepted in one cycle; load_ready = 0 until the wrap.
  - After frame_tick, pins scan AN/SEG in this order, each pair held 4 cycles: FE/08, FD/48, FB/01, F7/71, EF/08.
  - Digits 5–7 follow at AN = FF/SEG = 7F; the frame repeats every 32 cycles.
- Back-to-back loads: frame "9999" then "0000" offered with load_valid held.
  - The second is stalled (ready = 0) until the first commits.
  - It is accepted the cycle after the commit and displayed exactly one frame later; no frame is lost.
- DP and enable: disp_dp = 01, disp_en = 01, code 0x08 on digit 0 → DP = 0 and SEG = 00 only while AN = FE. DP = 1 and SEG = 7F otherwise.
- Font sweep: load each code 0x00–0x1F on digit 0 → SEG matches the font table, with 0x18–0x1F giving 7F.
- Reset mid-frame: assert CPU_RESETN low while AN = F7 with a load pending → outputs go to reset values asynchronously and the pending frame is never shown. After release, load_ready = 1.
